// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the dual-clock FIFO pointer blocks.
//   FIFO_ADDR_WIDTH : default memory address width (depth = 2**width)
//   bin2gray        : binary -> reflected Gray code
//   gray2bin        : Gray -> binary over the low 'width' bits
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 8;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB down; bits at or above width read 0.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] bin;
    logic        carry;
    bin   = 32'd0;
    carry = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < width) begin
        carry  = carry ^ gray[i];
        bin[i] = carry;
      end else begin
        bin[i] = 1'b0;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_full_if.sv
// wptr_full_if: write-side pointer bus between the write-pointer block and
// the rest of the write domain.
//   W_Inc     : write request
//   WQ2_Rptr  : Gray read pointer synchronized into the write clock domain
//   W_En      : memory write strobe
//   W_Addr    : memory write address
//   W_Ptr     : Gray write pointer toward the write-to-read synchronizer
//   W_Full    : FIFO full
//   W_Level   : occupancy seen from the write side
//   W_Ovf     : sticky write-while-full flag
//   W_AFull   : almost full (only with FIFO_ALMOST_FULL_EN)
// Modports: slave = the pointer block, master = its environment.
interface wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
  logic                  W_Inc;
  logic [ADDR_WIDTH:0]   WQ2_Rptr;
  logic                  W_En;
  logic [ADDR_WIDTH-1:0] W_Addr;
  logic [ADDR_WIDTH:0]   W_Ptr;
  logic                  W_Full;
  logic [ADDR_WIDTH:0]   W_Level;
  logic                  W_Ovf;
`ifdef FIFO_ALMOST_FULL_EN
  logic                  W_AFull;
`endif

  modport slave (
    input  W_Inc, WQ2_Rptr,
    output W_En, W_Addr, W_Ptr, W_Full, W_Level, W_Ovf
`ifdef FIFO_ALMOST_FULL_EN
    , output W_AFull
`endif
  );

  modport master (
    output W_Inc, WQ2_Rptr,
    input  W_En, W_Addr, W_Ptr, W_Full, W_Level, W_Ovf
`ifdef FIFO_ALMOST_FULL_EN
    , input W_AFull
`endif
  );

endinterface

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter (XOR prefix from the MSB).
// Shared by the write-side and read-side pointer blocks.
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
module gray2bin #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic [WIDTH-1:0] acc_s;

  // bin[i] = XOR of gray[WIDTH-1:i], built as a sum of right shifts.
  always_comb begin
    acc_s = gray;
    for (int i = 1; i < WIDTH; i++) begin
      acc_s = acc_s ^ (gray >> i);
    end
  end

  assign bin = acc_s;

endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer and full-flag generator for the dual-clock
// FIFO. Advances the binary write address and Gray write pointer on each
// accepted write and derives full, level and overflow from the read pointer
// already synchronized into this clock domain.
//   CLK  : write clock
//   RST  : synchronous active-high reset
//   bus  : wptr_full_if.slave (W_Inc, WQ2_Rptr in; W_En, W_Addr, W_Ptr,
//          W_Full, W_Level, W_Ovf and optional W_AFull out)
// Optional feature macro: FIFO_ALMOST_FULL_EN adds W_AFull with threshold
// AFULL_THRESH.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
`ifdef FIFO_ALMOST_FULL_EN
  , parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 4
`endif
) (
  input logic        CLK,
  input logic        RST,
  wptr_full_if.slave bus
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wptr_r;
  logic          full_r;
  logic [PW-1:0] level_r;
  logic          ovf_r;

  logic          accept_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rptr_full_s;
  logic          full_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next_s;

  gray2bin #(.WIDTH(PW)) u_rptr_g2b (
    .gray (bus.WQ2_Rptr),
    .bin  (rbin_s)
  );

  assign accept_s     = bus.W_Inc & ~full_r;
  assign wbin_next_s  = wbin_r + PW'(accept_s);
  assign wgray_next_s = wbin_next_s ^ (wbin_next_s >> 1);
  // Full pattern: read pointer one lap behind, i.e. top two Gray bits inverted.
  assign rptr_full_s  = {~bus.WQ2_Rptr[ADDR_WIDTH:ADDR_WIDTH-1], bus.WQ2_Rptr[ADDR_WIDTH-2:0]};
  assign full_next_s  = (wgray_next_s == rptr_full_s);
  assign level_next_s = wbin_next_s - rbin_s;

  // Pointer, flag and level registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin_r  <= '0;
      wptr_r  <= '0;
      full_r  <= 1'b0;
      level_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      wbin_r  <= wbin_next_s;
      wptr_r  <= wgray_next_s;
      full_r  <= full_next_s;
      level_r <= level_next_s;
      ovf_r   <= ovf_r | (bus.W_Inc & full_r);
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic afull_r;

  // Almost-full register, same timing as the full flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      afull_r <= 1'b0;
    end else begin
      afull_r <= (level_next_s >= PW'(AFULL_THRESH));
    end
  end

  assign bus.W_AFull = afull_r;
`endif

  // Strobe is held low during reset so no write lands in memory while
  // the pointer is being cleared.
  assign bus.W_En    = accept_s & ~RST;
  assign bus.W_Addr  = wbin_r[ADDR_WIDTH-1:0];
  assign bus.W_Ptr   = wptr_r;
  assign bus.W_Full  = full_r;
  assign bus.W_Level = level_r;
  assign bus.W_Ovf   = ovf_r;

endmodule
